// File: rtl/pe_button_debounce.sv
// Push-button responder: synchronises and debounces 5 buttons, latches sticky press
// events (write-one-to-clear) and counts presses, all readable from the CPU bridge.

module pe_button_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic stable,
    output logic rise
);
    logic [CNT_W-1:0] cnt;
    logic             at_limit;

    assign at_limit = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    // A rise is the cycle in which an accepted 0->1 change is committed to stable.
    assign rise     = sync_in & ~stable & at_limit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync_in == stable) begin
            cnt <= '0;
        end else if (at_limit) begin
            stable <= sync_in;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module pe_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [4:0]  button,
    output logic [31:0] rdata
);
    localparam int          NUM_LANES = 5;
    localparam logic [11:0] ADDR_STAT = 12'h078;
    localparam logic [11:0] ADDR_EVT  = 12'h07C;
    localparam logic [11:0] ADDR_CNT  = 12'h080;

    logic [NUM_LANES-1:0] sync1, sync2, stable, rise, evt;
    logic [15:0]          press_cnt;
    logic [2:0]           rise_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pe_button_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .sync_in(sync2[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) rise_cnt = rise_cnt + {2'b0, rise[i]};
    end

    // Set has priority over a coincident clear on both the event bits and the counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            evt       <= '0;
            press_cnt <= '0;
        end else begin
            if (wen && addr == ADDR_EVT) evt <= (evt & ~wdata[NUM_LANES-1:0]) | rise;
            else                         evt <= evt | rise;
            if (wen && addr == ADDR_CNT) press_cnt <= {13'b0, rise_cnt};
            else                         press_cnt <= press_cnt + {13'b0, rise_cnt};
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (addr)
            ADDR_STAT: rdata = {27'b0, stable};
            ADDR_EVT:  rdata = {27'b0, evt};
            ADDR_CNT:  rdata = {16'b0, press_cnt};
            default:   rdata = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_pe_button_debounce.sv
// Directed bench for pe_button_debounce: main instance at DEBOUNCE_CYCLES=4, a second
// instance at DEBOUNCE_CYCLES=1 so the 16-bit press counter can be wrapped quickly.

module tb_pe_button_debounce;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] addr = '0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [4:0]  button = '0;
    logic [31:0] rdata;

    logic [11:0] addr2 = 12'h080;
    logic        wen2 = 1'b0;
    logic [31:0] wdata2 = '0;
    logic [4:0]  button2 = '0;
    logic [31:0] rdata2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_button_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata),
        .button(button), .rdata(rdata)
    );

    pe_button_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(16)) dut_fast (
        .clk(clk), .rst(rst), .addr(addr2), .wen(wen2), .wdata(wdata2),
        .button(button2), .rdata(rdata2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        addr = a; wdata = d; wen = 1'b1;
        step(1);
        wen = 1'b0;
    endtask

    task automatic clear_all();
        button = '0;
        step(8);
        wr(12'h07C, 32'h1F);
        wr(12'h080, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0; button = 5'b11111;
        step(2);
        rd(12'h078, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_stat got=%h exp=%h", v, 32'h0); end
        rd(12'h07C, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_evt got=%h exp=%h", v, 32'h0); end
        rd(12'h080, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=%h", v, 32'h0); end
        rst = 1'b1;
        step(5);
        rd(12'h078, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_early got=%h exp=%h", v, 32'h0); end
        step(1);
        rd(12'h078, v); total++; if (v !== 32'h1F) begin bad++; $display("FAIL rst_stat6 got=%h exp=%h", v, 32'h1F); end
        rd(12'h07C, v); total++; if (v !== 32'h1F) begin bad++; $display("FAIL rst_evt6 got=%h exp=%h", v, 32'h1F); end
        rd(12'h080, v); total++; if (v !== 32'h5) begin bad++; $display("FAIL rst_cnt6 got=%h exp=%h", v, 32'h5); end
        clear_all();
    endtask

    task automatic test_clean_press();
        logic [31:0] v;
        button = 5'b00001;
        step(5);
        rd(12'h078, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL press_early got=%h exp=%h", v, 32'h0); end
        step(1);
        rd(12'h078, v); total++; if (v !== 32'h1) begin bad++; $display("FAIL press_stat got=%h exp=%h", v, 32'h1); end
        rd(12'h07C, v); total++; if (v !== 32'h1) begin bad++; $display("FAIL press_evt got=%h exp=%h", v, 32'h1); end
        rd(12'h080, v); total++; if (v !== 32'h1) begin bad++; $display("FAIL press_cnt got=%h exp=%h", v, 32'h1); end
        button = 5'b00000;
        step(5);
        rd(12'h078, v); total++; if (v !== 32'h1) begin bad++; $display("FAIL rel_early got=%h exp=%h", v, 32'h1); end
        step(1);
        rd(12'h078, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rel_stat got=%h exp=%h", v, 32'h0); end
        rd(12'h07C, v); total++; if (v !== 32'h1) begin bad++; $display("FAIL rel_evt got=%h exp=%h", v, 32'h1); end
        rd(12'h080, v); total++; if (v !== 32'h1) begin bad++; $display("FAIL rel_cnt got=%h exp=%h", v, 32'h1); end
        clear_all();
    endtask

    task automatic test_bounce();
        logic [31:0] v;
        logic        seen = 1'b0;
        for (int p = 0; p < 3; p++) begin
            button = 5'b00100;
            for (int c = 0; c < 3; c++) begin rd(12'h078, v); seen |= v[2]; step(1); end
            button = 5'b00000;
            rd(12'h078, v); seen |= v[2]; step(1);
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL bounce_glitch got=%b exp=%b", seen, 1'b0); end
        button = 5'b00100;
        step(5);
        rd(12'h078, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL bounce_early got=%h exp=%h", v, 32'h0); end
        step(1);
        rd(12'h078, v); total++; if (v !== 32'h4) begin bad++; $display("FAIL bounce_stat got=%h exp=%h", v, 32'h4); end
        rd(12'h07C, v); total++; if (v !== 32'h4) begin bad++; $display("FAIL bounce_evt got=%h exp=%h", v, 32'h4); end
        rd(12'h080, v); total++; if (v !== 32'h1) begin bad++; $display("FAIL bounce_cnt got=%h exp=%h", v, 32'h1); end
        clear_all();
    endtask

    task automatic test_w1c();
        logic [31:0] v;
        button = 5'b11111;
        step(6);
        button = 5'b00000;
        step(8);
        rd(12'h07C, v); total++; if (v !== 32'h1F) begin bad++; $display("FAIL w1c_pre got=%h exp=%h", v, 32'h1F); end
        wr(12'h07C, 32'h0000_0005);
        rd(12'h07C, v); total++; if (v !== 32'h1A) begin bad++; $display("FAIL w1c_clr got=%h exp=%h", v, 32'h1A); end
        wr(12'h07C, 32'hFFFF_FFE0);
        rd(12'h07C, v); total++; if (v !== 32'h1A) begin bad++; $display("FAIL w1c_hi got=%h exp=%h", v, 32'h1A); end
        wr(12'h078, 32'hFFFF_FFFF);
        rd(12'h07C, v); total++; if (v !== 32'h1A) begin bad++; $display("FAIL w1c_078 got=%h exp=%h", v, 32'h1A); end
        rd(12'h080, v); total++; if (v !== 32'h5) begin bad++; $display("FAIL w1c_cnt got=%h exp=%h", v, 32'h5); end
        clear_all();
    endtask

    task automatic test_collision();
        logic [31:0] v;
        button = 5'b01000;
        step(5);
        addr = 12'h07C; wdata = 32'h08; wen = 1'b1;
        step(1);
        wen = 1'b0;
        rd(12'h07C, v); total++; if (v !== 32'h08) begin bad++; $display("FAIL coll_evt got=%h exp=%h", v, 32'h08); end
        rd(12'h080, v); total++; if (v !== 32'h1) begin bad++; $display("FAIL coll_cnt1 got=%h exp=%h", v, 32'h1); end
        button = 5'b01011;
        step(5);
        addr = 12'h080; wdata = 32'h0; wen = 1'b1;
        step(1);
        wen = 1'b0;
        rd(12'h080, v); total++; if (v !== 32'h2) begin bad++; $display("FAIL coll_cnt2 got=%h exp=%h", v, 32'h2); end
        rd(12'h07C, v); total++; if (v !== 32'h0B) begin bad++; $display("FAIL coll_evt2 got=%h exp=%h", v, 32'h0B); end
        rd(12'h084, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL decode_084 got=%h exp=%h", v, 32'h0); end
        clear_all();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        button = 5'b10000;
        step(4);
        rst = 1'b0;
        step(1);
        rd(12'h078, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL mid_rst_stat got=%h exp=%h", v, 32'h0); end
        rst = 1'b1;
        step(5);
        rd(12'h078, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL mid_early got=%h exp=%h", v, 32'h0); end
        step(1);
        rd(12'h078, v); total++; if (v !== 32'h10) begin bad++; $display("FAIL mid_stat got=%h exp=%h", v, 32'h10); end
        rd(12'h07C, v); total++; if (v !== 32'h10) begin bad++; $display("FAIL mid_evt got=%h exp=%h", v, 32'h10); end
        rd(12'h080, v); total++; if (v !== 32'h1) begin bad++; $display("FAIL mid_cnt got=%h exp=%h", v, 32'h1); end
        clear_all();
    endtask

    // 13107 all-button presses give 65535 counts on the fast instance, then one more wraps.
    task automatic test_wrap();
        logic [31:0] v;
        addr2 = 12'h080;
        for (int k = 0; k < 13107; k++) begin
            button2 = 5'b11111; step(1);
            button2 = 5'b00000; step(1);
        end
        step(5);
        v = rdata2; total++; if (v !== 32'hFFFF) begin bad++; $display("FAIL wrap_pre got=%h exp=%h", v, 32'hFFFF); end
        button2 = 5'b00001;
        step(5);
        v = rdata2; total++; if (v !== 32'h0) begin bad++; $display("FAIL wrap_post got=%h exp=%h", v, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_w1c();
        test_collision();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
